sr_fetch: RTL
=============

Name: sr_fetch

Overview:
- Instruction-fetch and PC-sequencing stage of the multi-cycle schoolRISCV core, with a variable-latency instruction memory.
- Issues word requests to instruction memory and holds the returned instruction stable for decode/control.
- Consumes the control unit's pcSrc selection and the decoded immediates to compute the next PC.
- Provides pc and pcPlus4 (the latter for SAVE_NEXT_PC writeback), a retired-instruction counter and a sticky misaligned-target fault.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- CHECK_ALIGN, 1, 1 = raise fault on non-word-aligned next PC; 0 = no check, bits [1:0] forced to 0.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- imReq  out  1  instruction memory request, held until imValid.
- imAddr  out  32  instruction word address (byte address, [1:0]=0).
- imRdata  in  32  instruction data, sampled when imReq & imValid.
- imValid  in  1  response valid; may assert in the same cycle as imReq.
- instr  out  32  latched instruction to decode/control.
- instrValid  out  1  instruction executing this cycle; gates regWrite and memory writes downstream.
- stall  in  1  downstream hold; extends the execute cycle.
- pcSrc  in  2  next-PC select: 0 PC_PLUS_4, 1 PC_IMMB, 2 PC_IMMJ, 3 PC_REG_PLUS_IMM.
- immB  in  32  sign-extended B-type offset.
- immJ  in  32  sign-extended J-type offset.
- immI  in  32  sign-extended I-type offset (JALR).
- rd1  in  32  rs1 register value (JALR base).
- pc  out  32  address of instr.
- pcPlus4  out  32  pc + 4, combinational.
- instret  out  32  retired-instruction count.
- fault  out  1  sticky misaligned-target fault.
- faultPc  out  32  offending target address.

Behaviour:
- Clock: single clock, clk. Reset: rst, synchronous, active-high.
- States: FETCH, EXEC, FAULT.
- Reset values: state=FETCH, pc=RESET_VECTOR, instr=32'h0000_0013 (NOP), instret=0, fault=0, faultPc=0.
- While rst=1, imReq=0 and instrValid=0.
- FETCH:
  - imReq=1, imAddr=pc, instrValid=0.
  - On imValid=1, latch instr<=imRdata and go to EXEC at the next edge.
  - Otherwise stay in FETCH with imAddr stable.
- EXEC:
  - instrValid=1, imReq=0. instr and pc are stable for the whole state.
  - Next-PC target by pcSrc:
    - 0: pc+4
    - 1: pc+immB
    - 2: pc+immJ
    - 3: (rd1+immI) & ~32'h1
  - All additions are 32-bit modulo 2^32; wrap-around is silent.
  - If stall=1: remain in EXEC and ignore pcSrc. pcSrc/imm/rd1 may change while stalled; only the values in the final non-stalled EXEC cycle count.
  - If stall=0 and target[1:0]==0 (or CHECK_ALIGN=0): pc<=target with [1:0] cleared, instret<=instret+1 (wraps 32'hFFFF_FFFF -> 0), go to FETCH.
  - If stall=0, CHECK_ALIGN=1 and target[1:0]!=0:
    - fault<=1, faultPc<=target, go to FAULT.
    - pc and instret are not updated; the faulting instruction still retires its register write this cycle via instrValid.
- FAULT:
  - imReq=0, instrValid=0; all state held.
  - Exit only via rst.
- Memory contract:
  - imValid is ignored outside FETCH.
  - When imReq deasserts (including via rst), memory discards any pending response.
- Reset mid-operation: rst wins over every transition, including an imValid arriving in the same cycle. That instruction is discarded and instret is not incremented.
- Latency: minimum 2 cycles per instruction (imValid same cycle as imReq), plus one cycle per memory wait cycle and per stall cycle.
- pcPlus4 is always pc+4, independent of state.

Test Plan:
- Reset, then imValid asserted immediately for ADDI words -> imAddr sequence 0x0,0x4,0x8; instrValid pulses every 2nd cycle; instret=3 after the third EXEC.
- Memory with 3 wait cycles -> imAddr held at 0x4 for 4 cycles; instrValid stays low; instr unchanged until imValid.
- EXEC at pc=0x100 with pcSrc=1, immB=-8 -> next imAddr=0xF8. With pcSrc=2, immJ=0x800 -> next imAddr=0x900.
- pcSrc=3, rd1=0x203, immI=0 -> target 0x202 -> fault=1, faultPc=0x202, imReq stays 0; rst then restores pc=RESET_VECTOR and fault=0.
- stall=1 for 2 cycles in EXEC while pcSrc toggles -> instrValid high for 3 cycles; only the last-cycle pcSrc is applied; instret +1 only.
- rst asserted in the cycle imValid=1 -> instr stays NOP, instret=0, next imAddr=RESET_VECTOR. Separately, pc=0xFFFF_FFFC with pcSrc=0 -> wraps to 0x0 with no fault.

Source files
------------

// File: rtl/sr_fetch.sv
// sr_fetch: multi-cycle instruction fetch and PC sequencing with variable-latency memory
module sr_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter bit          CHECK_ALIGN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imReq,
    output logic [31:0] imAddr,
    input  logic [31:0] imRdata,
    input  logic        imValid,
    output logic [31:0] instr,
    output logic        instrValid,
    input  logic        stall,
    input  logic [1:0]  pcSrc,
    input  logic [31:0] immB,
    input  logic [31:0] immJ,
    input  logic [31:0] immI,
    input  logic [31:0] rd1,
    output logic [31:0] pc,
    output logic [31:0] pcPlus4,
    output logic [31:0] instret,
    output logic        fault,
    output logic [31:0] faultPc
);
    typedef enum logic [1:0] {FETCH, EXEC, FAULT} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, instret_q, instret_d, fpc_q, fpc_d;
    logic        fault_q, fault_d;
    logic [31:0] target;
    logic        misaligned;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            pc_q      <= RESET_VECTOR;
            instr_q   <= 32'h0000_0013;
            instret_q <= '0;
            fault_q   <= 1'b0;
            fpc_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            instret_q <= instret_d;
            fault_q   <= fault_d;
            fpc_q     <= fpc_d;
        end
    end
    always_comb begin
        target = pcSrc == 2'd0 ? pc_q + 32'd4 :
                 pcSrc == 2'd1 ? pc_q + immB :
                 pcSrc == 2'd2 ? pc_q + immJ : (rd1 + immI) & ~32'h1;
        misaligned = CHECK_ALIGN && target[1:0] != 2'b00;
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        instret_d = instret_q;
        fault_d   = fault_q;
        fpc_d     = fpc_q;
        case (state_q)
            FETCH: if (imValid) begin
                instr_d = imRdata;
                state_d = EXEC;
            end
            EXEC: if (!stall) begin
                // a faulting jump leaves pc/instret untouched so faultPc pairs with pc
                if (misaligned) begin
                    fault_d = 1'b1;
                    fpc_d   = target;
                    state_d = FAULT;
                end else begin
                    pc_d      = {target[31:2], 2'b00};
                    instret_d = instret_q + 32'd1;
                    state_d   = FETCH;
                end
            end
            default: ;
        endcase
    end
    always_comb begin
        imReq      = !rst && state_q == FETCH;
        instrValid = !rst && state_q == EXEC;
        imAddr     = pc_q;
        instr      = instr_q;
        pc         = pc_q;
        pcPlus4    = pc_q + 32'd4;
        instret    = instret_q;
        fault      = fault_q;
        faultPc    = fpc_q;
    end
endmodule
